// File: rtl/comm_pkg.sv
// Shared definitions for the Knight's Tour command link (host and robot sides).
package comm_pkg;

    localparam int BAUD_DIV = 2604;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_HI = 2'd1,
        SEND_LO = 2'd2
    } send_state_t;

endpackage

// File: rtl/uart.sv
// Full-duplex 8N1 UART transceiver; tx_done/rx_rdy are sticky flags cleared by
// trmt and by the next start bit (or clr_rx_rdy) respectively.
module uart import comm_pkg::*; #(
    parameter int BAUD_DIV = comm_pkg::BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV / 2 - 1);

    logic          r_tx_busy;
    logic [8:0]    r_tx_shift;
    logic [CW-1:0] r_tx_baud;
    logic [3:0]    r_tx_bits;
    logic          r_tx_done;
    logic          w_tx_bit_end;

    assign w_tx_bit_end = r_tx_busy && (r_tx_baud == BIT_LAST);

    // Shift register holds {data, start}; ones are shifted in so the stop bit falls out last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_busy  <= 1'b0;
            r_tx_shift <= '1;
            r_tx_baud  <= '0;
            r_tx_bits  <= '0;
            r_tx_done  <= 1'b0;
        end else if (trmt) begin
            r_tx_busy  <= 1'b1;
            r_tx_shift <= {tx_data, 1'b0};
            r_tx_baud  <= '0;
            r_tx_bits  <= '0;
            r_tx_done  <= 1'b0;
        end else if (r_tx_busy) begin
            if (w_tx_bit_end) begin
                r_tx_baud  <= '0;
                r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                r_tx_bits  <= r_tx_bits + 4'd1;
                if (r_tx_bits == 4'd9) begin
                    r_tx_busy <= 1'b0;
                    r_tx_done <= 1'b1;
                end
            end else begin
                r_tx_baud <= r_tx_baud + 1'b1;
            end
        end
    end

    assign TX      = r_tx_busy ? r_tx_shift[0] : 1'b1;
    assign tx_done = r_tx_done;

    logic          r_rx_sync1;
    logic          r_rx_sync2;
    logic          r_rx_prev;
    logic          r_rx_busy;
    logic [CW-1:0] r_rx_baud;
    logic [3:0]    r_rx_bits;
    logic [7:0]    r_rx_shift;
    logic [7:0]    r_rx_data;
    logic          r_rx_rdy;
    logic          w_rx_start;
    logic          w_rx_sample;

    assign w_rx_start  = !r_rx_busy && r_rx_prev && !r_rx_sync2;
    assign w_rx_sample = r_rx_busy && (r_rx_baud == '0);

    // Bit 0 is the start bit, 1..8 data, 9 the stop bit where the byte is published.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_busy  <= 1'b0;
            r_rx_baud  <= '0;
            r_rx_bits  <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_rdy   <= 1'b0;
        end else begin
            r_rx_sync1 <= RX;
            r_rx_sync2 <= r_rx_sync1;
            r_rx_prev  <= r_rx_sync2;
            if (w_rx_start) begin
                r_rx_busy <= 1'b1;
                r_rx_baud <= HALF_BIT;
                r_rx_bits <= '0;
                r_rx_rdy  <= 1'b0;
            end else begin
                if (clr_rx_rdy) begin
                    r_rx_rdy <= 1'b0;
                end
                if (w_rx_sample) begin
                    r_rx_baud <= BIT_LAST;
                    r_rx_bits <= r_rx_bits + 4'd1;
                    if (r_rx_bits == 4'd9) begin
                        r_rx_busy <= 1'b0;
                        r_rx_data <= r_rx_shift;
                        r_rx_rdy  <= 1'b1;
                    end else if (r_rx_bits != 4'd0) begin
                        r_rx_shift <= {r_rx_sync2, r_rx_shift[7:1]};
                    end
                end else if (r_rx_busy) begin
                    r_rx_baud <= r_rx_baud - 1'b1;
                end
            end
        end
    end

    assign rx_data = r_rx_data;
    assign rx_rdy  = r_rx_rdy;

endmodule

// File: rtl/remote_comm.sv
// Host-side command transmitter: sends a 16-bit command as two UART frames
// (high byte first) and exposes the last response byte received from the robot.
module remote_comm import comm_pkg::*; #(
    parameter int BAUD_DIV = comm_pkg::BAUD_DIV
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd_cmd,
    input  logic [15:0] cmd,
    input  logic        RX,
    output logic        TX,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    output logic        cmd_snt
);

    send_state_t r_state;
    send_state_t w_state_nxt;
    logic [7:0]  r_lo_byte;
    logic        r_cmd_snt;
    logic        w_trmt;
    logic [7:0]  w_tx_data;
    logic        w_accept;
    logic        w_done_lo;
    logic        w_tx_done;
    logic [7:0]  w_rx_data;
    logic        w_rx_rdy;

    uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .trmt       (w_trmt),
        .tx_data    (w_tx_data),
        .tx_done    (w_tx_done),
        .rx_data    (w_rx_data),
        .rx_rdy     (w_rx_rdy),
        .clr_rx_rdy (1'b0)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // tx_done is cleared by the same trmt that starts a frame, so SEND_HI never sees a stale done.
    always_comb begin
        w_state_nxt = r_state;
        w_trmt      = 1'b0;
        w_tx_data   = cmd[15:8];
        w_accept    = 1'b0;
        w_done_lo   = 1'b0;
        case (r_state)
            IDLE: begin
                if (snd_cmd) begin
                    w_accept    = 1'b1;
                    w_trmt      = 1'b1;
                    w_tx_data   = cmd[15:8];
                    w_state_nxt = SEND_HI;
                end
            end
            SEND_HI: begin
                if (w_tx_done) begin
                    w_trmt      = 1'b1;
                    w_tx_data   = r_lo_byte;
                    w_state_nxt = SEND_LO;
                end
            end
            SEND_LO: begin
                if (w_tx_done) begin
                    w_done_lo   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo_byte <= '0;
            r_cmd_snt <= 1'b0;
        end else if (w_accept) begin
            r_lo_byte <= cmd[7:0];
            r_cmd_snt <= 1'b0;
        end else if (w_done_lo) begin
            r_cmd_snt <= 1'b1;
        end
    end

    assign cmd_snt  = r_cmd_snt;
    assign resp     = w_rx_data;
    assign resp_rdy = w_rx_rdy;

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: TX is decoded by a behavioural 8N1 receiver, RX is
// driven with behavioural response frames; baud divider shortened for run time.
module tb_remote_comm;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snd_cmd = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic        RX = 1'b1;
    logic        TX;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        cmd_snt;

    int checks = 0;
    int errors = 0;
    int snt_rises = 0;
    logic [7:0] rxq[$];

    remote_comm #(.BAUD_DIV(BD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .snd_cmd  (snd_cmd),
        .cmd      (cmd),
        .RX       (RX),
        .TX       (TX),
        .resp     (resp),
        .resp_rdy (resp_rdy),
        .cmd_snt  (cmd_snt)
    );

    always #5 clk = ~clk;

    always @(posedge cmd_snt) snt_rises <= snt_rises + 1;

    // Behavioural line receiver: mid-bit sampling of TX, bytes queued in arrival order.
    always begin : tx_model
        logic [7:0] b;
        @(negedge TX);
        repeat (BD / 2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (BD) @(posedge clk);
            b[i] = TX;
        end
        repeat (BD) @(posedge clk);
        if (TX === 1'b1) rxq.push_back(b);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Sends c, checks cmd_snt timing, returns the two decoded bytes.
    task automatic send_cmd(input logic [15:0] c, input string tag, input int inject_at,
                            output logic [7:0] hi, output logic [7:0] lo);
        int n;
        int qb;
        qb = rxq.size();
        @(negedge clk);
        cmd = c;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        cmd = 16'($urandom);
        chk({tag, " snt_low"}, 32'(cmd_snt), 32'd0);
        chk({tag, " tx_start"}, 32'(TX), 32'd0);
        n = 1;
        while (cmd_snt !== 1'b1 && n < 30 * BD) begin
            @(negedge clk);
            n++;
            snd_cmd = (n == inject_at);
            if (n == inject_at) cmd = 16'hFFFF;
            if (n == 12 * BD) chk({tag, " snt_mid"}, 32'(cmd_snt), 32'd0);
        end
        snd_cmd = 1'b0;
        checks++;
        if (n < 20 * BD || n > 20 * BD + 4) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles expected %0d..%0d", tag, n, 20 * BD, 20 * BD + 4);
        end
        chk({tag, " snt_high"}, 32'(cmd_snt), 32'd1);
        chk({tag, " nbytes"}, 32'(rxq.size() - qb), 32'd2);
        hi = (rxq.size() > qb) ? rxq[qb] : 8'hxx;
        lo = (rxq.size() > qb + 1) ? rxq[qb + 1] : 8'hxx;
    endtask

    // Drives one response frame on RX and checks resp_rdy clear/set and resp.
    task automatic rx_frame(input logic [7:0] b);
        @(negedge clk);
        RX = 1'b0;
        repeat (4) @(negedge clk);
        chk("rx rdy_cleared", 32'(resp_rdy), 32'd0);
        repeat (BD - 4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) @(negedge clk);
        end
        RX = 1'b1;
        chk("rx rdy_not_early", 32'(resp_rdy), 32'd0);
        repeat (BD) @(negedge clk);
        chk("rx rdy_set", 32'(resp_rdy), 32'd1);
        chk("rx resp", 32'(resp), 32'(b));
    endtask

    typedef struct {
        logic [15:0] cmd;
        logic [7:0]  exp_hi;
        logic [7:0]  exp_lo;
    } vec_t;

    initial begin
        vec_t vecs[6];
        logic [7:0] rx_bytes[4];
        logic [7:0] hi, lo;
        logic [15:0] c;
        int base;

        vecs[0] = '{16'h14FE, 8'h14, 8'hFE};
        vecs[1] = '{16'h265D, 8'h26, 8'h5D};
        vecs[2] = '{16'h3967, 8'h39, 8'h67};
        vecs[3] = '{16'h0000, 8'h00, 8'h00};
        vecs[4] = '{16'hFFFF, 8'hFF, 8'hFF};
        vecs[5] = '{16'h8001, 8'h80, 8'h01};
        rx_bytes = '{8'hC3, 8'h00, 8'hFF, 8'h5A};

        repeat (3) @(negedge clk);
        chk("reset TX", 32'(TX), 32'd1);
        chk("reset cmd_snt", 32'(cmd_snt), 32'd0);
        chk("reset resp_rdy", 32'(resp_rdy), 32'd0);
        chk("reset resp", 32'(resp), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            send_cmd(vecs[i].cmd, "vec", 0, hi, lo);
            chk("vec hi", 32'(hi), 32'(vecs[i].exp_hi));
            chk("vec lo", 32'(lo), 32'(vecs[i].exp_lo));
        end

        for (int i = 0; i < 6; i++) begin
            c = 16'($urandom);
            repeat ($urandom_range(0, 5 * BD)) @(negedge clk);
            send_cmd(c, "rand", 0, hi, lo);
            chk("rand word", 32'({hi, lo}), 32'(c));
        end

        base = snt_rises;
        send_cmd(16'h1234, "ignore", 5 * BD, hi, lo);
        repeat (25 * BD) @(negedge clk);
        chk("ignore word", 32'({hi, lo}), 32'h1234);
        chk("ignore rises", 32'(snt_rises - base), 32'd1);
        chk("ignore no_extra_frame", 32'(cmd_snt), 32'd1);

        @(negedge clk);
        cmd = 16'hBEEF;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        repeat (3 * BD) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort TX", 32'(TX), 32'd1);
        chk("abort cmd_snt", 32'(cmd_snt), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (25 * BD) @(negedge clk);
        chk("abort stays_idle TX", 32'(TX), 32'd1);
        chk("abort no_late_snt", 32'(cmd_snt), 32'd0);
        send_cmd(16'hA55A, "post_reset", 0, hi, lo);
        chk("post_reset word", 32'({hi, lo}), 32'hA55A);

        for (int i = 0; i < 4; i++) rx_frame(rx_bytes[i]);
        for (int i = 0; i < 4; i++) rx_frame(8'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
